// File: rtl/gmii_rx_frame_stats.sv
// Per-port GMII receive frame statistics with coherent 64-bit register reads.
// Optional FCS checking is built when GMII_RX_STATS_FCS_CHECK_EN is defined.
module gmii_rx_frame_stats #(
  parameter int NUM_PORTS     = 2,
  parameter int CNT_WIDTH     = 64,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int ADDR_WIDTH    = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_PORTS-1:0] gmii_rxd,
  input  logic [NUM_PORTS-1:0]   gmii_rx_dv,
  input  logic [NUM_PORTS-1:0]   gmii_rx_er,
  input  logic [NUM_PORTS-1:0]   clr,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [31:0]            rd_data,
  output logic                   rd_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;
  localparam int PW = ADDR_WIDTH - 3;

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t CMAX = '1;

  logic [NUM_PORTS-1:0][1:0]           st_q, st_d;
  logic [NUM_PORTS-1:0][15:0]          len_q, len_d;
  logic [NUM_PORTS-1:0][15:0]          last_q, last_d;
  logic [NUM_PORTS-1:0]                er_q, er_d;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] good_q, good_d;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] bad_q, bad_d;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] byt_q, byt_d;
  logic [NUM_PORTS-1:0][31:0]          shg_q, shg_d;
  logic [NUM_PORTS-1:0][31:0]          shb_q, shb_d;
  logic [NUM_PORTS-1:0][31:0]          shy_q, shy_d;
`ifdef GMII_RX_STATS_FCS_CHECK_EN
  logic [NUM_PORTS-1:0][31:0]          crc_q, crc_d;
  logic [NUM_PORTS-1:0][31:0]          fcs_q, fcs_d;
`endif
  logic [31:0]   rdat;
  logic [31:0]   rd_data_q;
  logic          rd_valid_q;
  logic [PW-1:0] rport;
  logic [2:0]    rreg;

  assign rport    = rd_addr[ADDR_WIDTH-1:3];
  assign rreg     = rd_addr[2:0];
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CMAX) ? v : v + cnt_t'(1);
  endfunction

  function automatic cnt_t sat_add(input cnt_t v, input logic [15:0] n);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, v} + {{(CNT_WIDTH-15){1'b0}}, n};
    return s[CNT_WIDTH] ? CMAX : s[CNT_WIDTH-1:0];
  endfunction

  function automatic logic [63:0] ext(input cnt_t v);
    return 64'(v);
  endfunction

`ifdef GMII_RX_STATS_FCS_CHECK_EN
  function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                           input logic [7:0]  d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return r;
  endfunction
`endif

  always_comb begin : p_port
    logic        dv;
    logic        erb;
    logic        fin;
    logic        ok;
    logic        crc_ok;
    logic        in_rng;
    logic [7:0]  d8;
    logic [63:0] tmp;
    st_d   = st_q;
    len_d  = len_q;
    last_d = last_q;
    er_d   = er_q;
    good_d = good_q;
    bad_d  = bad_q;
    byt_d  = byt_q;
    shg_d  = shg_q;
    shb_d  = shb_q;
    shy_d  = shy_q;
`ifdef GMII_RX_STATS_FCS_CHECK_EN
    crc_d  = crc_q;
    fcs_d  = fcs_q;
`endif
    for (int p = 0; p < NUM_PORTS; p++) begin
      dv  = gmii_rx_dv[p];
      erb = gmii_rx_er[p];
      d8  = gmii_rxd[8*p +: 8];
      fin = 1'b0;
      tmp = '0;
      unique case (st_q[p])
        S_IDLE: begin
          if (dv) begin
            er_d[p] = erb;
            if (d8 == 8'h55) begin
              st_d[p] = S_PRE;
            end else if (d8 == 8'hD5) begin
              st_d[p]  = S_BODY;
              len_d[p] = '0;
`ifdef GMII_RX_STATS_FCS_CHECK_EN
              crc_d[p] = '1;
`endif
            end else begin
              st_d[p] = S_DROP;
            end
          end
        end
        S_PRE: begin
          if (!dv) begin
            fin     = 1'b1;
            st_d[p] = S_IDLE;
          end else begin
            er_d[p] = er_q[p] | erb;
            if (d8 == 8'hD5) begin
              st_d[p]  = S_BODY;
              len_d[p] = '0;
`ifdef GMII_RX_STATS_FCS_CHECK_EN
              crc_d[p] = '1;
`endif
            end else if (d8 != 8'h55) begin
              st_d[p] = S_DROP;
            end
          end
        end
        S_BODY: begin
          if (dv) begin
            er_d[p]  = er_q[p] | erb;
            len_d[p] = (len_q[p] == 16'hFFFF) ? len_q[p] : len_q[p] + 16'd1;
`ifdef GMII_RX_STATS_FCS_CHECK_EN
            crc_d[p] = crc_byte(crc_q[p], d8);
`endif
          end else begin
            fin       = 1'b1;
            last_d[p] = len_q[p];
            st_d[p]   = S_IDLE;
          end
        end
        S_DROP: begin
          if (!dv) begin
            fin     = 1'b1;
            st_d[p] = S_IDLE;
          end else begin
            er_d[p] = er_q[p] | erb;
          end
        end
        default: st_d[p] = S_IDLE;
      endcase
`ifdef GMII_RX_STATS_FCS_CHECK_EN
      crc_ok = (rev32(crc_q[p]) == 32'hC704DD7B);
`else
      crc_ok = 1'b1;
`endif
      in_rng = (32'(len_q[p]) >= MIN_FRAME_LEN) &&
               (32'(len_q[p]) <= MAX_FRAME_LEN);
      ok = (st_q[p] == S_BODY) && !er_q[p] && in_rng && crc_ok;
      if (clr[p]) begin
        good_d[p] = '0;
        bad_d[p]  = '0;
        byt_d[p]  = '0;
        shg_d[p]  = '0;
        shb_d[p]  = '0;
        shy_d[p]  = '0;
`ifdef GMII_RX_STATS_FCS_CHECK_EN
        fcs_d[p]  = '0;
`endif
      end else begin
        if (fin) begin
          if (ok) begin
            good_d[p] = sat_inc(good_q[p]);
            byt_d[p]  = sat_add(byt_q[p], len_q[p]);
          end else begin
            bad_d[p] = sat_inc(bad_q[p]);
          end
`ifdef GMII_RX_STATS_FCS_CHECK_EN
          if ((st_q[p] == S_BODY) && !crc_ok && (fcs_q[p] != '1))
            fcs_d[p] = fcs_q[p] + 32'd1;
`endif
        end
        // low-word reads capture the high word of the pre-update value
        if (rd_en && (rport == PW'(p))) begin
          if (rreg == 3'd0) begin
            tmp      = ext(good_q[p]);
            shg_d[p] = tmp[63:32];
          end
          if (rreg == 3'd2) begin
            tmp      = ext(bad_q[p]);
            shb_d[p] = tmp[63:32];
          end
          if (rreg == 3'd4) begin
            tmp      = ext(byt_q[p]);
            shy_d[p] = tmp[63:32];
          end
        end
      end
    end
  end

  always_comb begin : p_rmux
    logic [63:0] v;
    rdat = '0;
    v    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rport == PW'(p)) begin
        unique case (rreg)
          3'd0: begin v = ext(good_q[p]); rdat = v[31:0]; end
          3'd1: rdat = shg_q[p];
          3'd2: begin v = ext(bad_q[p]); rdat = v[31:0]; end
          3'd3: rdat = shb_q[p];
          3'd4: begin v = ext(byt_q[p]); rdat = v[31:0]; end
          3'd5: rdat = shy_q[p];
          3'd6: rdat = {last_q[p], 14'd0, st_q[p]};
`ifdef GMII_RX_STATS_FCS_CHECK_EN
          3'd7: rdat = fcs_q[p];
`else
          3'd7: rdat = '0;
`endif
          default: rdat = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= '0;
      len_q      <= '0;
      last_q     <= '0;
      er_q       <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      byt_q      <= '0;
      shg_q      <= '0;
      shb_q      <= '0;
      shy_q      <= '0;
`ifdef GMII_RX_STATS_FCS_CHECK_EN
      crc_q      <= '0;
      fcs_q      <= '0;
`endif
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      len_q      <= len_d;
      last_q     <= last_d;
      er_q       <= er_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      byt_q      <= byt_d;
      shg_q      <= shg_d;
      shb_q      <= shb_d;
      shy_q      <= shy_d;
`ifdef GMII_RX_STATS_FCS_CHECK_EN
      crc_q      <= crc_d;
      fcs_q      <= fcs_d;
`endif
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rdat;
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame_stats.sv
// Bench for gmii_rx_frame_stats: frame-level counter model checked through
// the register port on every cycle.
module tb_gmii_rx_frame_stats;

  localparam int NP = 2;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rxd;
  logic [1:0]  dv;
  logic [1:0]  er;
  logic [1:0]  clr;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  always #4 clk = ~clk;

  gmii_rx_frame_stats dut (
    .clk       (clk),
    .rst       (rst),
    .gmii_rxd  (rxd),
    .gmii_rx_dv(dv),
    .gmii_rx_er(er),
    .clr       (clr),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] m_good[NP];
  logic [63:0] m_bad[NP];
  logic [63:0] m_byt[NP];
  logic [31:0] m_fcs[NP];
  logic [15:0] m_last[NP];
  logic [31:0] m_sh[NP][3];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;
  logic [1:0][63:0] fv;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic logic [63:0] s_inc(input logic [63:0] v);
    return (&v) ? v : v + 64'd1;
  endfunction

  function automatic logic [63:0] s_add(input logic [63:0] v, input int n);
    logic [64:0] s;
    s = {1'b0, v} + 65'(n);
    return s[64] ? '1 : s[63:0];
  endfunction

  function automatic logic [31:0] crc32(input bq_t q, input int s,
                                        input int n);
    logic [31:0] c;
    c = '1;
    for (int i = s; i < s + n; i++) begin
      c ^= {24'd0, q[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // preamble, SFD, n-4 payload bytes and a correct FCS
  function automatic bq_t mk(input int npre, input int n, input int seed);
    bq_t q;
    logic [31:0] c;
    for (int i = 0; i < npre; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 0; i < n - 4; i++) q.push_back(8'(i * 7 + seed));
    c = crc32(q, npre + 1, n - 4);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    q.push_back(c[23:16]);
    q.push_back(c[31:24]);
    return q;
  endfunction

  task automatic model_frame(input int p, input bq_t q, input int er_idx);
    int  i;
    int  n;
    int  sz;
    bit  fcs_ok;
    bit  good;
    sz = q.size();
    i  = 0;
    while (i < sz && q[i] == 8'h55) i++;
    if (i >= sz || q[i] != 8'hD5) begin
      m_bad[p] = s_inc(m_bad[p]);
      return;
    end
    n = sz - i - 1;
    m_last[p] = (n > 65535) ? 16'hFFFF : 16'(n);
    fcs_ok = 1'b1;
`ifdef GMII_RX_STATS_FCS_CHECK_EN
    fcs_ok = (n >= 4) && (crc32(q, i + 1, n - 4) ==
             {q[sz-1], q[sz-2], q[sz-3], q[sz-4]});
    if (!fcs_ok && m_fcs[p] != '1) m_fcs[p] = m_fcs[p] + 32'd1;
`endif
    good = (er_idx < 0 || er_idx >= sz) && n >= 64 && n <= 1518 && fcs_ok;
    if (good) begin
      m_good[p] = s_inc(m_good[p]);
      m_byt[p]  = s_add(m_byt[p], n);
    end else begin
      m_bad[p] = s_inc(m_bad[p]);
    end
  endtask

  task automatic send(input int p, input bq_t q, input int er_idx,
                      input bit clr_end);
    foreach (q[i]) begin
      @(negedge clk);
      clr          = '0;
      rxd[8*p +: 8] = q[i];
      dv[p]        = 1'b1;
      er[p]        = (i == er_idx);
    end
    @(negedge clk);
    dv[p]         = 1'b0;
    er[p]         = 1'b0;
    rxd[8*p +: 8] = 8'h00;
    model_frame(p, q, er_idx);
    if (clr_end) begin
      clr[p]    = 1'b1;
      m_good[p] = '0;
      m_bad[p]  = '0;
      m_byt[p]  = '0;
      m_fcs[p]  = '0;
      for (int k = 0; k < 3; k++) m_sh[p][k] = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clr = '0;
    end
  endtask

  task automatic rd(input int p, input int r);
    logic [31:0] e;
    @(negedge clk);
    clr     = '0;
    rd_en   = 1'b1;
    rd_addr = {4'(p), 3'(r)};
    e = '0;
    if (p < NP) begin
      case (r)
        0: begin e = m_good[p][31:0]; m_sh[p][0] = m_good[p][63:32]; end
        1: e = m_sh[p][0];
        2: begin e = m_bad[p][31:0]; m_sh[p][1] = m_bad[p][63:32]; end
        3: e = m_sh[p][1];
        4: begin e = m_byt[p][31:0]; m_sh[p][2] = m_byt[p][63:32]; end
        5: e = m_sh[p][2];
        6: e = {m_last[p], 16'h0000};
`ifdef GMII_RX_STATS_FCS_CHECK_EN
        7: e = m_fcs[p];
`endif
        default: e = '0;
      endcase
    end
    exp_q.push_back(e);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("rd_valid", {63'd0, rd_valid}, 64'd1);
        chk("rd_data", {32'd0, rd_data}, {32'd0, e});
        last_rd = e;
      end else begin
        chk("rd_valid_idle", {63'd0, rd_valid}, 64'd0);
        chk("rd_data_hold", {32'd0, rd_data}, {32'd0, last_rd});
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    rxd = '0; dv = '0; er = '0; clr = '0; rd_en = 1'b0; rd_addr = '0;
    for (int p = 0; p < NP; p++) begin
      m_good[p] = '0; m_bad[p] = '0; m_byt[p] = '0;
      m_fcs[p] = '0; m_last[p] = '0;
      for (int k = 0; k < 3; k++) m_sh[p][k] = '0;
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle(2);
    for (int r = 0; r < 8; r++) rd(0, r);
    rd(1, 0);

    send(0, mk(7, 64, 1), -1, 1'b0);
    idle(2);
    rd(0, 0); rd(0, 1); rd(0, 2); rd(0, 4); rd(0, 6);
    chk("pin_t1_good", m_good[0], 64'd1);
    chk("pin_t1_bytes", m_byt[0], 64'd64);
    chk("pin_t1_bad", m_bad[0], 64'd0);

    send(1, mk(7, 60, 2), -1, 1'b0);
    send(1, mk(7, 64, 3), 18, 1'b0);
    idle(2);
    rd(1, 0); rd(1, 2); rd(1, 3); rd(0, 0); rd(0, 4);
    chk("pin_t2_bad", m_bad[1], 64'd2);
    chk("pin_t2_good", m_good[1], 64'd0);

    send(1, mk(0, 64, 4), -1, 1'b0);
    send(1, mk(3, 63, 5), -1, 1'b0);
    send(1, mk(7, 1518, 6), -1, 1'b0);
    send(1, mk(7, 1519, 7), -1, 1'b0);
    q = {8'h55, 8'h55, 8'h20, 8'h11, 8'h22};
    send(1, q, -1, 1'b0);
    q = {8'h55, 8'h55, 8'h55};
    send(1, q, -1, 1'b0);
    q = {8'h12, 8'h34, 8'h56};
    send(1, q, -1, 1'b0);
    idle(2);
    rd(1, 0); rd(1, 2); rd(1, 4); rd(1, 6); rd(1, 7); rd(5, 0); rd(5, 6);
    chk("pin_bnd_good", m_good[1], 64'd2);
    chk("pin_bnd_bad", m_bad[1], 64'd7);
    chk("pin_bnd_bytes", m_byt[1], 64'd1582);

    fv[1] = m_good[1];
    fv[0] = 64'h0000_0001_FFFF_FFFF;
    @(negedge clk);
    force dut.good_q = fv;
    @(negedge clk);
    release dut.good_q;
    m_good[0] = fv[0];
    send(0, mk(7, 64, 8), -1, 1'b0);
    idle(1);
    rd(0, 0);
    send(0, mk(7, 80, 9), -1, 1'b0);
    idle(1);
    rd(0, 1); rd(0, 0); rd(0, 1);
    chk("pin_t3_good", m_good[0], 64'h0000_0002_0000_0001);

    fv[1] = m_good[1];
    fv[0] = '1;
    @(negedge clk);
    force dut.good_q = fv;
    @(negedge clk);
    release dut.good_q;
    m_good[0] = fv[0];
    send(0, mk(7, 64, 10), -1, 1'b0);
    idle(1);
    rd(0, 0); rd(0, 1);
    chk("pin_t4_good", m_good[0], 64'hFFFF_FFFF_FFFF_FFFF);

    fv[1] = m_byt[1];
    fv[0] = 64'hFFFF_FFFF_FFFF_FFC0;
    @(negedge clk);
    force dut.byt_q = fv;
    @(negedge clk);
    release dut.byt_q;
    m_byt[0] = fv[0];
    send(0, mk(7, 100, 11), -1, 1'b0);
    idle(1);
    rd(0, 4); rd(0, 5);
    chk("pin_bytes_sat", m_byt[0], 64'hFFFF_FFFF_FFFF_FFFF);

    send(0, mk(7, 64, 12), -1, 1'b1);
    idle(2);
    rd(0, 0); rd(0, 1); rd(0, 2); rd(0, 4); rd(0, 5); rd(1, 0);
    chk("pin_clr_good", m_good[0], 64'd0);
    send(0, mk(7, 100, 13), -1, 1'b0);
    idle(2);
    rd(0, 0); rd(0, 4); rd(0, 6);
    chk("pin_t5_good", m_good[0], 64'd1);
    chk("pin_t5_bytes", m_byt[0], 64'd100);

`ifdef GMII_RX_STATS_FCS_CHECK_EN
    q = mk(7, 64, 14);
    send(0, q, -1, 1'b0);
    q[q.size()-1] = q[q.size()-1] ^ 8'hFF;
    send(0, q, -1, 1'b0);
    idle(2);
    rd(0, 0); rd(0, 2); rd(0, 7);
    chk("pin_fcs_good", m_good[0], 64'd2);
    chk("pin_fcs_bad", m_bad[0], 64'd1);
    chk("pin_fcs_cnt", {32'd0, m_fcs[0]}, 64'd1);
`endif

    idle(4);
    chk("exp_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gmii_rx_frame_stats.md
Name: gmii_rx_frame_stats

Overview:
- Per-port GMII receive statistics block for NUM_PORTS monitored ports; passively taps each port's rxd/rx_dv/rx_er after the GMII mux.
- Parses frames (preamble, SFD, body) and keeps saturating 64-bit counters for good frames, bad frames and good bytes.
- Counters are read over a simple 32-bit register port. Reading a low word latches the matching high word into a shadow register, so the 64-bit value is read coherently as two 32-bit halves.

Parameters:
- NUM_PORTS, 2, number of monitored GMII ports (1..16).
- CNT_WIDTH, 64, counter width (33..64); upper bits read as 0 above CNT_WIDTH.
- MIN_FRAME_LEN, 64, minimum good length in bytes, after SFD, FCS included.
- MAX_FRAME_LEN, 1518, maximum good length in bytes.
- ADDR_WIDTH, 7, register address width; must be >= clog2(NUM_PORTS)+3.

Ports:
- clk  in  1  GMII/register clock (125 MHz).
- rst  in  1  synchronous, active-high reset.
- gmii_rxd  in  8*NUM_PORTS  receive data; port p uses [8p+7:8p].
- gmii_rx_dv  in  NUM_PORTS  data valid per port.
- gmii_rx_er  in  NUM_PORTS  receive error per port.
- clr  in  NUM_PORTS  one-cycle pulse; clears that port's counters.
- rd_en  in  1  register read strobe.
- rd_addr  in  ADDR_WIDTH  {port, reg[2:0]}.
- rd_data  out  32  read data.
- rd_valid  out  1  high one cycle after rd_en.

Behaviour:
- Reset: all counters 0, shadows 0, all FSMs in IDLE, rd_data=0, rd_valid=0.
- Per-port FSM states: IDLE, PREAMBLE, BODY, DROP.
  - IDLE: rx_dv=1 and rxd=0x55 -> PREAMBLE. rx_dv=1 and rxd=0xD5 -> BODY (short preamble accepted). rx_dv=1 with any other byte -> DROP.
  - PREAMBLE: 0x55 stays. 0xD5 -> BODY. Any other byte -> DROP. rx_dv=0 -> bad frame, then IDLE.
  - BODY: each rx_dv=1 cycle increments a 16-bit length counter that saturates at 0xFFFF. rx_dv=0 ends the frame: evaluate, then IDLE.
  - DROP: wait for rx_dv=0, count one bad frame, then IDLE.
- rx_er sampled high at any point while rx_dv=1 in a frame marks that frame bad.
- Good frame: no rx_er, MIN_FRAME_LEN <= len <= MAX_FRAME_LEN.
  - good_frames += 1; good_bytes += len.
  - Otherwise bad_frames += 1.
- Counter update happens in the cycle after rx_dv falls. Back-to-back frames with a 1-cycle rx_dv gap must both be counted.
- All counters saturate at 2^CNT_WIDTH-1; no wrap. good_bytes saturates rather than overflowing on the add.
- Register map per port (reg):
  - 0 good_lo, 1 good_hi
  - 2 bad_lo, 3 bad_hi
  - 4 bytes_lo, 5 bytes_hi
  - 6 status: [1:0] FSM state, [31:16] last length
  - 7 reads 0
- Read of any _lo register returns the registered low 32 bits and latches bits [63:32] of the same counter into that register's shadow. _hi reads return the shadow.
- Read latency: rd_data and rd_valid are registered; both appear 1 cycle after rd_en. rd_data holds its value until the next read.
- rd_addr port field >= NUM_PORTS returns 0 with rd_valid=1.
- Same-cycle read and increment: the read returns the pre-increment value.
- clr[p]: zeroes port p's counters and shadows next cycle.
  - clr wins over a same-cycle frame completion; that frame is not counted.
  - The FSM is not reset, so a frame in progress is counted normally on its end.
- rst asserted mid-frame: the FSM returns to IDLE and the frame is lost. Bytes remaining after rst deassertion with rx_dv=1 are handled from IDLE, which normally means DROP.

Optional Feature:
- Macro GMII_RX_STATS_FCS_CHECK_EN.
- Defined:
  - Per-port CRC-32 (IEEE 802.3, reflected, init 0xFFFFFFFF) is computed over BODY bytes.
  - A residue other than 0xC704DD7B at frame end marks the frame bad.
  - Reg 7 becomes fcs_err_lo with a matching saturating 32-bit counter; bad_frames also increments.
- Not defined: no CRC logic, FCS is not checked, reg 7 reads 0.

Test Plan:
- Port0: 7x0x55, 0xD5, 64 body bytes, rx_dv low -> good_lo=1, bytes_lo=64, bad_lo=0, rd_valid one cycle after rd_en.
- Port1: 60-byte body, then a 64-byte body with rx_er high on byte 10 -> bad_lo=2, good_lo=0; port0 counters unaffected.
- Preload good_frames=0x0000_0001_FFFF_FFFF via force, send one good frame, read lo then hi -> 0x00000000 then 0x00000002. A further frame arriving between the lo and hi reads does not change the hi value.
- Force good_frames to all-ones, send a good frame -> counter stays 0xFFFF_FFFF_FFFF_FFFF.
- Pulse clr[0] in the same cycle as a frame completes -> good_lo=0. Next 100-byte frame -> good_lo=1, bytes_lo=100.
- With GMII_RX_STATS_FCS_CHECK_EN: a 64-byte frame with a correct FCS gives good=1; the same frame with the last byte flipped gives bad=1 and reg7=1.
